dmem_port_arbiter: RTL and testbench

- Shares the single-port data RAM (12-bit word address, 32-bit data, synchronous read) between the processor and one peripheral master, e.g. the unlock-mechanism keypad/servo controller.
- The processor cannot stall, so it has absolute priority.
- The peripheral's request is buffered and issued only in cycles where the processor makes no memory access.
- Sits between processor, RAM and peripheral; the RAM's wEn/addr/dataIn/dataOut connect only to this block.

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_port_arbiter_if.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W       = 12;
    localparam int ARB_DATA_W       = 32;
    localparam int ARB_STARVE_LIMIT = 255;

    // IDLE: nothing held; PEND: request buffered; RD_WAIT: read data arriving;
    // DONE: completion pulse.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    // Width needed to hold 0..limit; never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of processor, peripheral and RAM signals around the arbiter.
// slave = arbiter view, master = surrounding system view.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    // processor side
    logic              cpu_mem_en;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_q;
    // peripheral side
    logic              per_req;
    logic              per_ready;
    logic              per_we;
    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_wdata;
    logic              per_done;
    logic [DATA_W-1:0] per_rdata;
    logic              per_starved;
    // RAM side
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  cpu_mem_en, cpu_wren, cpu_addr, cpu_data,
        output cpu_q,
        input  per_req, per_we, per_addr, per_wdata,
        output per_ready, per_done, per_rdata, per_starved,
        output ram_wen, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output cpu_mem_en, cpu_wren, cpu_addr, cpu_data,
        input  cpu_q,
        output per_req, per_we, per_addr, per_wdata,
        input  per_ready, per_done, per_rdata, per_starved,
        input  ram_wen, ram_addr, ram_din,
        output ram_dout
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data RAM arbiter: the processor always wins, a single buffered
// peripheral request is issued only in cycles the processor leaves the RAM idle.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input logic             clock,
    input logic             reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int               CNT_W   = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e        state_q,     state_d;
    logic              buf_we_q,    buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q,  buf_addr_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;

    // State, request buffer, wait counter and captured read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for a free RAM cycle in PEND.
    always_comb begin
        state_d     = state_q;
        buf_we_d    = buf_we_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.per_req) begin
                    buf_we_d    = bus.per_we;
                    buf_addr_d  = bus.per_addr;
                    buf_wdata_d = bus.per_wdata;
                    wait_cnt_d  = '0;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (bus.cpu_mem_en) begin
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end else begin
                    // Issue cycle: the RAM sees the buffered request now.
                    wait_cnt_d = '0;
                    state_d    = buf_we_q ? DONE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                // ram_dout holds the buffered address's data this cycle,
                // whatever the processor is doing to the address lines.
                rdata_d = bus.ram_dout;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port mux: processor first, then a pending peripheral request.
    always_comb begin
        bus.ram_addr = bus.cpu_addr;
        bus.ram_din  = bus.cpu_data;
        bus.ram_wen  = 1'b0;
        if (bus.cpu_mem_en) begin
            bus.ram_wen = bus.cpu_wren;
        end else if (state_q == PEND) begin
            bus.ram_addr = buf_addr_q;
            bus.ram_din  = buf_wdata_q;
            bus.ram_wen  = buf_we_q;
        end
    end

    assign bus.cpu_q       = bus.ram_dout;
    assign bus.per_ready   = (state_q == IDLE);
    assign bus.per_done    = (state_q == DONE);
    assign bus.per_rdata   = rdata_q;
    assign bus.per_starved = (wait_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous RAM.
module tb_dmem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    dmem_port_arbiter #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    // Behavioural single-port RAM, synchronous read.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Start of next cycle: inputs for this cycle are driven right after.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle observation point.
    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle_all();
        bus.cpu_mem_en = 1'b0;
        bus.cpu_wren   = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_data   = '0;
        bus.per_req    = 1'b0;
        bus.per_we     = 1'b0;
        bus.per_addr   = '0;
        bus.per_wdata  = '0;
    endtask

    task automatic cpu_access(input logic wr, input logic [11:0] a, input logic [31:0] d);
        bus.cpu_mem_en = 1'b1;
        bus.cpu_wren   = wr;
        bus.cpu_addr   = a;
        bus.cpu_data   = d;
    endtask

    task automatic cpu_off();
        bus.cpu_mem_en = 1'b0;
        bus.cpu_wren   = 1'b0;
    endtask

    task automatic per_request(input logic wr, input logic [11:0] a, input logic [31:0] d);
        bus.per_req   = 1'b1;
        bus.per_we    = wr;
        bus.per_addr  = a;
        bus.per_wdata = d;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.ram_dout = '0;
        idle_all();
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        look();
        chk("rst_done",    {31'd0, bus.per_done},    32'd0);
        chk("rst_rdata",   bus.per_rdata,            32'd0);
        chk("rst_starved", {31'd0, bus.per_starved}, 32'd0);
        rst = 1'b0;
        look();
        chk("rst_ready",   {31'd0, bus.per_ready},   32'd1);

        // Peripheral write, CPU idle
        cyc(); per_request(1'b1, 12'h010, 32'h0000_00A5);
        look(); chk("wr_accept_ready", {31'd0, bus.per_ready}, 32'd1);
        cyc(); bus.per_req = 1'b0;
        look();
        chk("wr_issue_wen",  {31'd0, bus.ram_wen},   32'd1);
        chk("wr_issue_addr", {20'd0, bus.ram_addr},  32'h010);
        chk("wr_issue_din",  bus.ram_din,            32'h0000_00A5);
        chk("wr_issue_rdy",  {31'd0, bus.per_ready}, 32'd0);
        cyc(); look(); chk("wr_done", {31'd0, bus.per_done}, 32'd1);
        cyc(); look();
        chk("wr_done_clear", {31'd0, bus.per_done},  32'd0);
        chk("wr_ready_back", {31'd0, bus.per_ready}, 32'd1);
        cyc(); cpu_access(1'b0, 12'h010, 32'd0);
        look(); chk("cpu_lw_wen", {31'd0, bus.ram_wen}, 32'd0);
        cyc(); cpu_off();
        look(); chk("cpu_lw_q", bus.cpu_q, 32'h0000_00A5);

        // Peripheral read under 5 cycles of CPU contention
        cyc(); cpu_access(1'b1, 12'h020, 32'hDEAD_BEEF);
        look(); chk("preload_wen", {31'd0, bus.ram_wen}, 32'd1);
        cyc(); cpu_off();
        cyc(); per_request(1'b0, 12'h020, 32'd0); cpu_access(1'b0, 12'h100, 32'd0);
        look();
        for (int i = 0; i < 5; i++) begin
            cyc(); bus.per_req = 1'b0;
            look();
            chk($sformatf("rd_blocked_addr%0d", i), {20'd0, bus.ram_addr}, 32'h100);
            chk($sformatf("rd_blocked_done%0d", i), {31'd0, bus.per_done}, 32'd0);
        end
        cyc(); cpu_off();
        look();
        chk("rd_issue_addr", {20'd0, bus.ram_addr}, 32'h020);
        chk("rd_issue_wen",  {31'd0, bus.ram_wen},  32'd0);
        cyc(); cpu_access(1'b0, 12'h100, 32'd0);
        look();
        chk("rd_wait_done",  {31'd0, bus.per_done},  32'd0);
        chk("rd_wait_ready", {31'd0, bus.per_ready}, 32'd0);
        cyc(); look();
        chk("rd_done",  {31'd0, bus.per_done}, 32'd1);
        chk("rd_rdata", bus.per_rdata,         32'hDEAD_BEEF);
        cyc(); cpu_off(); look();
        chk("rd_done_clear", {31'd0, bus.per_done}, 32'd0);
        chk("rd_rdata_hold", bus.per_rdata,         32'hDEAD_BEEF);

        // CPU priority on the same address
        cyc(); per_request(1'b1, 12'h030, 32'hCAFE_0001);
        look();
        cyc(); bus.per_req = 1'b0; cpu_access(1'b1, 12'h030, 32'h0000_1234);
        look();
        chk("prio_cpu_wen", {31'd0, bus.ram_wen}, 32'd1);
        chk("prio_cpu_din", bus.ram_din,          32'h0000_1234);
        cyc(); cpu_off();
        look();
        chk("prio_per_wen",  {31'd0, bus.ram_wen},  32'd1);
        chk("prio_per_addr", {20'd0, bus.ram_addr}, 32'h030);
        chk("prio_per_din",  bus.ram_din,           32'hCAFE_0001);
        cyc(); look(); chk("prio_done", {31'd0, bus.per_done}, 32'd1);
        cyc(); cpu_access(1'b0, 12'h030, 32'd0);
        look();
        cyc(); cpu_off();
        look(); chk("prio_final", bus.cpu_q, 32'hCAFE_0001);

        // Back-pressure: request held high, accepts only every third cycle
        cyc(); per_request(1'b1, 12'h050, 32'h0000_0077);
        for (int k = 0; k < 9; k++) begin
            if (k != 0) cyc();
            look();
            chk($sformatf("bp_ready%0d", k), {31'd0, bus.per_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("bp_done%0d", k),  {31'd0, bus.per_done},  (k % 3 == 2) ? 32'd1 : 32'd0);
        end
        cyc(); bus.per_req = 1'b0;
        look(); chk("bp_idle", {31'd0, bus.per_ready}, 32'd1);

        // Starvation with STARVE_LIMIT=4
        cyc(); per_request(1'b0, 12'h010, 32'd0); cpu_access(1'b0, 12'h200, 32'd0);
        look();
        for (int w = 1; w <= 10; w++) begin
            cyc(); bus.per_req = 1'b0;
            look();
            chk($sformatf("starve_w%0d", w), {31'd0, bus.per_starved}, (w >= 5) ? 32'd1 : 32'd0);
        end
        cyc(); cpu_off();
        look();
        chk("starve_issue_addr", {20'd0, bus.ram_addr},     32'h010);
        chk("starve_issue_flag", {31'd0, bus.per_starved},  32'd1);
        cyc(); look(); chk("starve_cleared", {31'd0, bus.per_starved}, 32'd0);
        cyc(); look();
        chk("starve_rd_done",  {31'd0, bus.per_done}, 32'd1);
        chk("starve_rd_rdata", bus.per_rdata,         32'h0000_00A5);

        // Reset during RD_WAIT
        cyc(); per_request(1'b0, 12'h030, 32'd0);
        look();
        cyc(); bus.per_req = 1'b0;
        look();
        cyc(); look();
        chk("mid_rst_rdwait", {31'd0, bus.per_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rdata", bus.per_rdata,         32'd0);
        chk("mid_rst_done",  {31'd0, bus.per_done}, 32'd0);
        repeat (2) @(posedge clk);
        look(); rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc(); look();
            chk($sformatf("post_rst_done%0d", j), {31'd0, bus.per_done}, 32'd0);
        end
        chk("post_rst_ready",   {31'd0, bus.per_ready},   32'd1);
        chk("post_rst_rdata",   bus.per_rdata,            32'd0);
        chk("post_rst_starved", {31'd0, bus.per_starved}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
